// File: rtl/i2c_slave_regs.sv
// I2C slave with an auto-incrementing 8-bit register file.
// The first written byte after the address sets the pointer; later bytes write or read.
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h4C,
    parameter int         REG_DEPTH  = 16,
    parameter int         PTR_W      = $clog2(REG_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic             wr_strobe,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [7:0]       wr_data,
    output logic             busy,
    input  logic [PTR_W-1:0] loc_addr,
    output logic [7:0]       loc_data
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WACK,
        RDATA,
        RACK,
        WAIT_STOP
    } state_t;

    state_t           state;
    logic [7:0]       regs [REG_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [7:0]       shreg;
    logic [2:0]       bit_cnt;
    logic             rw;
    logic             mack;

    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;

    // Bus idles high, so the synchroniser also resets high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl_in;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    logic       scl_rise;
    logic       scl_fall;
    logic       start_c;
    logic       stop_c;
    logic [7:0] nbyte;
    logic       addr_hit;
    logic [7:0] rd_byte;
    logic [PTR_W-1:0] ptr_inc;

    assign scl_rise = scl_s2 & ~scl_d;
    assign scl_fall = ~scl_s2 & scl_d;
    assign start_c  = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_c   = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign nbyte    = {shreg[6:0], sda_s2};
    assign addr_hit = (nbyte[7:1] == SLAVE_ADDR);
    assign rd_byte  = regs[ptr];
    assign ptr_inc  = ptr + 1'b1;
    assign loc_data = regs[loc_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sda_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_ptr    <= '0;
            wr_data   <= 8'h00;
            busy      <= 1'b0;
            ptr       <= '0;
            shreg     <= 8'h00;
            bit_cnt   <= 3'd0;
            rw        <= 1'b0;
            mack      <= 1'b0;
            for (int i = 0; i < REG_DEPTH; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            wr_strobe <= 1'b0;
            if (start_c) begin
                state   <= ADDR;
                bit_cnt <= 3'd7;
                sda_oe  <= 1'b0;
            end else if (stop_c) begin
                state  <= IDLE;
                busy   <= 1'b0;
                sda_oe <= 1'b0;
            end else begin
                unique case (state)
                    IDLE, WAIT_STOP: begin
                        sda_oe <= 1'b0;
                    end
                    ADDR: begin
                        if (scl_rise) begin
                            shreg   <= nbyte;
                            bit_cnt <= bit_cnt - 3'd1;
                            if (bit_cnt == 3'd0) begin
                                if (addr_hit) begin
                                    state <= ADDR_ACK;
                                    rw    <= sda_s2;
                                    busy  <= 1'b1;
                                end else begin
                                    state <= WAIT_STOP;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    // First falling edge starts the ACK, second one ends it.
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                bit_cnt <= 3'd7;
                                if (rw) begin
                                    state  <= RDATA;
                                    shreg  <= rd_byte;
                                    sda_oe <= ~rd_byte[7];
                                end else begin
                                    state  <= PTR;
                                    sda_oe <= 1'b0;
                                end
                            end
                        end
                    end
                    PTR: begin
                        if (scl_rise) begin
                            shreg   <= nbyte;
                            bit_cnt <= bit_cnt - 3'd1;
                            if (bit_cnt == 3'd0) begin
                                ptr   <= nbyte[PTR_W-1:0];
                                state <= PTR_ACK;
                            end
                        end
                    end
                    PTR_ACK, WACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 3'd7;
                                state   <= WDATA;
                            end
                        end
                    end
                    WDATA: begin
                        if (scl_rise) begin
                            shreg   <= nbyte;
                            bit_cnt <= bit_cnt - 3'd1;
                            if (bit_cnt == 3'd0) begin
                                regs[ptr] <= nbyte;
                                wr_strobe <= 1'b1;
                                wr_ptr    <= ptr;
                                wr_data   <= nbyte;
                                ptr       <= ptr_inc;
                                state     <= WACK;
                            end
                        end
                    end
                    RDATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd0) begin
                                sda_oe <= 1'b0;
                                state  <= RACK;
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                                shreg   <= {shreg[6:0], 1'b0};
                                sda_oe  <= ~shreg[6];
                            end
                        end
                    end
                    // Master ACK advances the pointer before the next byte loads.
                    RACK: begin
                        if (scl_rise) begin
                            mack <= ~sda_s2;
                            if (!sda_s2) begin
                                ptr <= ptr_inc;
                            end
                        end else if (scl_fall) begin
                            if (mack) begin
                                state   <= RDATA;
                                shreg   <= rd_byte;
                                sda_oe  <= ~rd_byte[7];
                                bit_cnt <= 3'd7;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: bit-banged master, write scoreboard and read queue.
// Register model tracks pointer and contents independently of the DUT.
module tb_i2c_slave_regs;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_oe;
    logic       wr_strobe;
    logic [3:0] wr_ptr;
    logic [7:0] wr_data;
    logic       busy;
    logic [3:0] loc_addr = 4'd0;
    logic [7:0] loc_data;
    logic       sda_line;

    assign sda_line = sda_m & ~sda_oe;

    int n_checks = 0;
    int n_fail = 0;
    int oe_hi_bad = 0;
    logic oe_prev = 1'b0;
    logic oe_seen = 1'b0;
    logic busy_seen = 1'b0;

    logic [11:0] wq [$];
    logic [7:0]  rq [$];
    logic [11:0] wexp;
    logic [7:0]  exp_regs [16];
    logic [3:0]  mptr = 4'd0;

    always #5 clk = ~clk;

    i2c_slave_regs #(
        .SLAVE_ADDR(7'h4C),
        .REG_DEPTH (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .wr_strobe(wr_strobe),
        .wr_ptr   (wr_ptr),
        .wr_data  (wr_data),
        .busy     (busy),
        .loc_addr (loc_addr),
        .loc_data (loc_data)
    );

    always @(negedge clk) begin
        if (rst_n && wr_strobe) begin
            n_checks++;
            if (wq.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: got ptr %0d data %02h, required no write",
                         wr_ptr, wr_data);
            end else begin
                wexp = wq.pop_front();
                if ({wr_ptr, wr_data} !== wexp) begin
                    n_fail++;
                    $display("FAIL wr_scoreboard: got ptr %0d data %02h, required ptr %0d data %02h",
                             wr_ptr, wr_data, wexp[11:8], wexp[7:0]);
                end
            end
        end
        if (scl && (sda_oe !== oe_prev)) oe_hi_bad++;
        oe_prev = sda_oe;
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_io(input logic b, output logic s);
        wait_clk(Q);
        sda_m = b;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        s = sda_line;
        wait_clk(Q);
        scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_io(d[i], s);
        bit_io(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, s);
            d[i] = s;
        end
        bit_io(~ack, s);
    endtask

    task automatic bus_start();
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        scl = 1'b0;
    endtask

    task automatic bus_rstart();
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(2 * Q);
    endtask

    task automatic exp_write(input logic [7:0] d);
        wq.push_back({mptr, d});
        exp_regs[mptr] = d;
        mptr = mptr + 4'd1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
        wait_clk(3);
        n_checks++;
        if ({sda_oe, busy, wr_strobe, wr_ptr, wr_data} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got oe%b busy%b stb%b ptr%0d data%02h, required all 0",
                     sda_oe, busy, wr_strobe, wr_ptr, wr_data);
        end
        for (int i = 0; i < 16; i++) begin
            loc_addr = 4'(i);
            #1;
            n_checks++;
            if (loc_data !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got %02h required 00", i, loc_data);
            end
        end
        rst_n = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_write();
        logic ack;
        logic [7:0] b [4];
        b = '{8'h98, 8'h03, 8'hA5, 8'h5A};
        bus_start();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) mptr = b[i][3:0];
            if (i >= 2) exp_write(b[i]);
            send_byte(b[i], ack);
            n_checks++;
            if (ack !== 1'b1) begin
                n_fail++;
                $display("FAIL write_ack%0d: got %b required 1", i, ack);
            end
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL write_busy: got %b required 1", busy);
        end
        bus_stop();
        n_checks++;
        if (busy !== 1'b0 || wq.size() != 0) begin
            n_fail++;
            $display("FAIL write_end: got busy %b pending %0d, required 0 and 0",
                     busy, wq.size());
        end
        for (int i = 3; i <= 4; i++) begin
            loc_addr = 4'(i);
            #1;
            n_checks++;
            if (loc_data !== exp_regs[i]) begin
                n_fail++;
                $display("FAIL write_loc%0d: got %02h required %02h", i, loc_data, exp_regs[i]);
            end
        end
    endtask

    task automatic read_from(input logic [7:0] p, input int nbytes, input string tag);
        logic ack;
        logic [7:0] d;
        logic [7:0] e;
        bus_start();
        send_byte(8'h98, ack);
        n_checks++;
        if (ack !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_addr_ack: got %b required 1", tag, ack);
        end
        mptr = p[3:0];
        send_byte(p, ack);
        bus_rstart();
        send_byte(8'h99, ack);
        n_checks++;
        if (ack !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_raddr_ack: got %b required 1", tag, ack);
        end
        for (int i = 0; i < nbytes; i++) begin
            rq.push_back(exp_regs[mptr]);
            recv_byte(i != nbytes - 1, d);
            e = rq.pop_front();
            n_checks++;
            if (d !== e) begin
                n_fail++;
                $display("FAIL %s_rdata%0d: got %02h required %02h", tag, i, d, e);
            end
            if (i != nbytes - 1) mptr = mptr + 4'd1;
        end
        wait_clk(Q);
        n_checks++;
        if (sda_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release: got sda_oe %b required 0", tag, sda_oe);
        end
        bus_stop();
    endtask

    task automatic test_read_rstart();
        read_from(8'h03, 2, "read");
    endtask

    task automatic test_wrong_addr();
        logic ack;
        oe_seen = 1'b0;
        busy_seen = 1'b0;
        bus_start();
        send_byte(8'h9A, ack);
        n_checks++;
        if (ack !== 1'b0) begin
            n_fail++;
            $display("FAIL wrong_addr_ack: got %b required 0", ack);
        end
        send_byte(8'h00, ack);
        bus_stop();
        n_checks++;
        if (oe_seen !== 1'b0 || busy_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL wrong_addr_quiet: got oe_seen %b busy_seen %b, required 0 0",
                     oe_seen, busy_seen);
        end
    endtask

    task automatic test_wrap();
        logic ack;
        bus_start();
        send_byte(8'h98, ack);
        mptr = 4'hF;
        send_byte(8'h0F, ack);
        exp_write(8'h11);
        send_byte(8'h11, ack);
        exp_write(8'h22);
        send_byte(8'h22, ack);
        bus_stop();
        loc_addr = 4'hF;
        #1;
        n_checks++;
        if (loc_data !== 8'h11) begin
            n_fail++;
            $display("FAIL wrap_reg15: got %02h required 11", loc_data);
        end
        loc_addr = 4'h0;
        #1;
        n_checks++;
        if (loc_data !== 8'h22) begin
            n_fail++;
            $display("FAIL wrap_reg0: got %02h required 22", loc_data);
        end
        read_from(8'h0F, 2, "wrap_read");
    endtask

    task automatic test_abort();
        logic ack;
        logic s;
        logic [3:0] nib;
        nib = 4'b1011;
        bus_start();
        send_byte(8'h98, ack);
        mptr = 4'h5;
        send_byte(8'h05, ack);
        for (int i = 3; i >= 0; i--) bit_io(nib[i], s);
        bus_stop();
        loc_addr = 4'h5;
        #1;
        n_checks++;
        if (busy !== 1'b0 || sda_oe !== 1'b0 || loc_data !== exp_regs[5]) begin
            n_fail++;
            $display("FAIL abort_state: got busy %b oe %b reg5 %02h, required 0 0 %02h",
                     busy, sda_oe, loc_data, exp_regs[5]);
        end
    endtask

    task automatic test_reset_midxfer();
        logic ack;
        logic s;
        logic [7:0] a;
        a = 8'h98;
        bus_start();
        for (int i = 7; i >= 0; i--) bit_io(a[i], s);
        wait_clk(Q);
        n_checks++;
        if (sda_oe !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_ack_drive: got sda_oe %b required 1", sda_oe);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (sda_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_release: got sda_oe %b required 0", sda_oe);
        end
        for (int i = 0; i < 16; i++) exp_regs[i] = 8'h00;
        mptr = 4'd0;
        wq.delete();
        for (int i = 0; i < 16; i++) begin
            loc_addr = 4'(i);
            #1;
            n_checks++;
            if (loc_data !== 8'h00) begin
                n_fail++;
                $display("FAIL mid_reset_reg%0d: got %02h required 00", i, loc_data);
            end
        end
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(2);
        bit_io(1'b1, s);
        n_checks++;
        if (s !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_after_reset_ack: got line %b required 1", s);
        end
        bus_stop();
        bus_start();
        send_byte(8'h98, ack);
        mptr = 4'h1;
        send_byte(8'h01, ack);
        exp_write(8'h33);
        send_byte(8'h33, ack);
        n_checks++;
        if (ack !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_recover_ack: got %b required 1", ack);
        end
        bus_stop();
        loc_addr = 4'h1;
        #1;
        n_checks++;
        if (loc_data !== 8'h33) begin
            n_fail++;
            $display("FAIL mid_recover_reg1: got %02h required 33", loc_data);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_rstart();
        test_wrong_addr();
        test_wrap();
        test_abort();
        test_reset_midxfer();
        wait_clk(4);
        n_checks++;
        if (wq.size() != 0) begin
            n_fail++;
            $display("FAIL wr_missing: got %0d pending writes required 0", wq.size());
        end
        n_checks++;
        if (oe_hi_bad != 0) begin
            n_fail++;
            $display("FAIL oe_scl_high: got %0d sda_oe changes with SCL high required 0",
                     oe_hi_bad);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
